// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with combinational lookup, same-cycle bypass and saturating stats
module branch_target_buffer #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        btb_hit,
  output logic [31:0] btb_target,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic        ex_br_en,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        stall,
  input  logic        flush_all,
  output logic [31:0] hit_count,
  output logic [31:0] update_count
);
  localparam int IDX = $clog2(NUM_ENTRIES);
  localparam int TW = 30 - IDX;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [TW-1:0] tag_q [NUM_ENTRIES];
  logic [29:0] tgt_q [NUM_ENTRIES];
  logic [31:0] hit_q, hit_d, upd_q, upd_d;
  logic [IDX-1:0] if_idx, ex_idx;
  logic [TW-1:0] if_tag;
  logic upd, byp, hit_raw;
  logic unused;
  assign unused = ^{if_pc[1:0], ex_pc[1:0], ex_target[1:0]};
  assign if_idx = if_pc[IDX+1:2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign if_tag = if_pc[31:IDX+2];
  always_comb begin
    upd = ex_valid & ~stall & ~rst & ~flush_all & (((ex_opcode == OP_BR) & ex_br_en) | (ex_opcode == OP_JAL));
    // a resolving update to the looked-up PC wins before the array is written
    byp = upd & (if_pc[31:2] == ex_pc[31:2]);
    hit_raw = valid_q[if_idx] & (tag_q[if_idx] == if_tag);
    btb_hit = ~rst & (byp | hit_raw);
    btb_target = rst ? 32'h0 : byp ? {ex_target[31:2], 2'b00} : hit_raw ? {tgt_q[if_idx], 2'b00} : 32'h0;
    hit_d = (btb_hit & ~stall & ~&hit_q) ? hit_q + 32'd1 : hit_q;
    upd_d = (upd & ~&upd_q) ? upd_q + 32'd1 : upd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      hit_q <= '0;
      upd_q <= '0;
    end else begin
      hit_q <= hit_d;
      upd_q <= upd_d;
      if (flush_all) valid_q <= '0;
      else if (upd) valid_q[ex_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (upd) begin
      tag_q[ex_idx] <= ex_pc[31:IDX+2];
      tgt_q[ex_idx] <= ex_target[31:2];
    end
  end
  assign hit_count = hit_q;
  assign update_count = upd_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed vectors plus an every-cycle behavioural model check
module tb_branch_target_buffer;
  localparam int NE = 16;
  localparam int IDX = 4;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ALU = 7'b0110011;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] if_pc = '0, ex_pc = '0, ex_target = '0;
  logic ex_valid = 1'b0, ex_br_en = 1'b0, stall = 1'b0, flush_all = 1'b0;
  logic [6:0] ex_opcode = '0;
  logic btb_hit;
  logic [31:0] btb_target, hit_count, update_count;
  int n_chk = 0, n_fail = 0;
  bit mval [NE];
  logic [31:0] mtag [NE], mtgt [NE];
  logic [31:0] mhit = '0, mupd = '0;
  branch_target_buffer #(.NUM_ENTRIES(NE)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .btb_hit(btb_hit), .btb_target(btb_target),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_br_en(ex_br_en), .ex_pc(ex_pc),
    .ex_target(ex_target), .stall(stall), .flush_all(flush_all),
    .hit_count(hit_count), .update_count(update_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic bit m_upd();
    return !rst && ex_valid && !stall && !flush_all && ((ex_opcode == BR && ex_br_en) || ex_opcode == JAL);
  endfunction
  function automatic logic [32:0] m_out();
    int i;
    if (rst) return '0;
    if (m_upd() && (if_pc >> 2) == (ex_pc >> 2)) return {1'b1, ex_target & ~32'h3};
    i = int'((if_pc >> 2) % NE);
    if (mval[i] && mtag[i] == (if_pc >> (IDX + 2))) return {1'b1, mtgt[i]};
    return '0;
  endfunction
  always @(negedge clk) begin
    logic [32:0] o;
    o = m_out();
    chk("model_hit", {31'b0, btb_hit}, {31'b0, o[32]});
    chk("model_target", btb_target, o[31:0]);
    chk("model_hit_count", hit_count, mhit);
    chk("model_update_count", update_count, mupd);
  end
  always @(posedge clk) begin
    logic [32:0] o;
    int i;
    o = m_out();
    if (rst) begin
      for (int k = 0; k < NE; k++) mval[k] = 0;
      mhit = 0;
      mupd = 0;
    end else begin
      if (o[32] && !stall && mhit != 32'hFFFF_FFFF) mhit++;
      if (flush_all) for (int k = 0; k < NE; k++) mval[k] = 0;
      else if (m_upd()) begin
        i = int'((ex_pc >> 2) % NE);
        mval[i] = 1;
        mtag[i] = ex_pc >> (IDX + 2);
        mtgt[i] = ex_target & ~32'h3;
        if (mupd != 32'hFFFF_FFFF) mupd++;
      end
    end
  end
  task automatic drive(input logic v, input logic [6:0] op, input logic br, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic st, input logic fl, input logic [31:0] ipc);
    ex_valid = v; ex_opcode = op; ex_br_en = br; ex_pc = pc; ex_target = tgt;
    stall = st; flush_all = fl; if_pc = ipc;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input string name, input logic [31:0] pc, input logic eh, input logic [31:0] et);
    if_pc = pc;
    #1;
    chk({name, "_hit"}, {31'b0, btb_hit}, {31'b0, eh});
    chk({name, "_target"}, btb_target, et);
  endtask
  initial begin
    drive(0, ALU, 0, 0, 0, 0, 0, 32'h40);
    step(); step();
    rst = 1'b0;
    look("reset", 32'h40, 0, 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_update_count", update_count, 0);
    drive(1, BR, 1, 32'h104, 32'h200, 0, 0, 32'h40);
    step();
    drive(0, ALU, 0, 0, 0, 0, 0, 32'h40);
    look("hit_104", 32'h104, 1, 32'h200);
    look("alias_144", 32'h144, 0, 0);
    chk("upd_cnt_1", update_count, 1);
    step();
    drive(1, JAL, 0, 32'h300, 32'h380, 0, 0, 32'h300);
    look("bypass_300", 32'h300, 1, 32'h380);
    step();
    drive(0, ALU, 0, 0, 0, 0, 0, 32'h300);
    look("after_300", 32'h300, 1, 32'h380);
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(1, JAL, 0, 32'h500, 32'h580, 1, 0, 32'h40);
        1: drive(1, BR, 0, 32'h500, 32'h580, 0, 0, 32'h40);
        2: drive(1, JALR, 1, 32'h500, 32'h580, 0, 0, 32'h40);
        3: drive(0, JAL, 1, 32'h500, 32'h580, 0, 0, 32'h40);
        default: drive(1, ALU, 1, 32'h500, 32'h580, 0, 0, 32'h40);
      endcase
      step();
      drive(0, ALU, 0, 0, 0, 0, 0, 32'h40);
      look($sformatf("noupd_%0d", c), 32'h500, 0, 0);
      chk($sformatf("noupd_cnt_%0d", c), update_count, 2);
    end
    drive(1, JAL, 0, 32'h400, 32'h480, 0, 1, 32'h400);
    look("flush_nobypass", 32'h400, 0, 0);
    step();
    drive(0, ALU, 0, 0, 0, 0, 0, 32'h40);
    look("flush_104", 32'h104, 0, 0);
    look("flush_300", 32'h300, 0, 0);
    look("flush_400", 32'h400, 0, 0);
    chk("flush_upd_cnt", update_count, 2);
    step();
    force dut.upd_q = 32'hFFFF_FFFF;
    mupd = 32'hFFFF_FFFF;
    #1;
    release dut.upd_q;
    #1;
    chk("sat_preset", update_count, 32'hFFFF_FFFF);
    drive(1, JAL, 0, 32'h104, 32'h600, 0, 0, 32'h40);
    step();
    drive(0, ALU, 0, 0, 0, 0, 0, 32'h40);
    chk("sat_hold", update_count, 32'hFFFF_FFFF);
    look("sat_entry", 32'h104, 1, 32'h600);
    rst = 1'b1;
    look("rst_force", 32'h104, 0, 0);
    step();
    chk("rst_upd_cnt", update_count, 0);
    chk("rst_hit_cnt", hit_count, 0);
    rst = 1'b0;
    look("rst_cleared", 32'h104, 0, 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
